// File: rtl/usb_ep_pkg.sv
// Shared definitions for the USB endpoint FIFO: default depth, pointer width
// helper, configuration word field positions and IN packet FSM states.
package usb_ep_pkg;

   // Default FIFO depth in bytes (power of two, at most 64).
   localparam int unsigned EP_DEPTH_DEFAULT = 64;

   // Endpoint configuration word layout.
   localparam int unsigned EP_CFG_W       = 14;
   localparam int unsigned EP_CFG_DIR     = 13;  // 1 = IN, 0 = OUT
   localparam int unsigned EP_CFG_MPS_MSB = 6;
   localparam int unsigned EP_CFG_MPS_LSB = 0;

   // Width of occupancy, packet length and packet down-counter.
   localparam int unsigned EP_CNT_W = 7;

   // Read/write pointer width for a power-of-two depth; never below one bit.
   function automatic int unsigned ep_ptr_w(input int unsigned depth);
      return (depth < 2) ? 32'd1 : 32'($clog2(depth));
   endfunction

   // IN packet handshake toward the USB core.
   typedef enum logic [1:0] {
      PKT_IDLE  = 2'd0,   // no packet committed
      PKT_READY = 2'd1,   // packet committed, waiting for the first core pop
      PKT_XFER  = 2'd2    // core is draining the committed packet
   } pkt_state_e;

endpackage

// File: rtl/usb_ep_ram.sv
// Endpoint byte storage: DEPTH x 8 array, write registered on the rising
// clock edge, read combinational so the FIFO head falls through.
module usb_ep_ram
   import usb_ep_pkg::*;
#(
   parameter int unsigned DEPTH = EP_DEPTH_DEFAULT,
   parameter int unsigned AW    = ep_ptr_w(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [AW-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem_q [DEPTH];

   // Byte write at the clock edge.
   // NOTE: the array has no reset; contents are only meaningful behind the
   // FIFO's own count, and a reset term would stop it mapping onto RAM cells.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   // Asynchronous read of the current head location.
   always_comb begin
      rdata = mem_q[raddr];
   end

endmodule

// File: rtl/usb_ep_fifo.sv
// USB endpoint FIFO. One byte FIFO shared by both transfer directions:
//   IN  (cfg_i[13]=1): function pushes, core pops in committed packets.
//   OUT (cfg_i[13]=0): core pushes, function pops.
// A small FSM frames IN data into packets for the core; flush or a change of
// direction empties the FIFO and abandons any packet in one cycle.
module usb_ep_fifo
   import usb_ep_pkg::*;
#(
   parameter int unsigned DEPTH = EP_DEPTH_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [EP_CFG_W-1:0] cfg_i,
   output logic [EP_CFG_W-1:0] ep_cfg,
   output logic [7:0]          ep_din,
   input  logic                ep_re,
   input  logic [7:0]          ep_dout,
   input  logic                ep_we,
   output logic                ep_empty,
   output logic                ep_full,
   output logic                ep_bf_en,
   output logic [EP_CNT_W-1:0] ep_bf_size,
   input  logic [7:0]          f_wdata,
   input  logic                f_we,
   input  logic                f_eop,
   output logic [7:0]          f_rdata,
   input  logic                f_re,
   output logic [EP_CNT_W-1:0] f_count,
   input  logic                flush,
   output logic                err_ovf,
   output logic                err_udf
);

   localparam int unsigned         AW        = ep_ptr_w(DEPTH);
   localparam logic [EP_CNT_W-1:0] DEPTH_CNT = EP_CNT_W'(DEPTH);

   // Registered state.
   logic [EP_CFG_W-1:0] cfg_q,      cfg_d;
   logic [AW-1:0]       wr_ptr_q,   wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q,   rd_ptr_d;
   logic [EP_CNT_W-1:0] count_q,    count_d;
   logic                err_ovf_q,  err_ovf_d;
   logic                err_udf_q,  err_udf_d;
   pkt_state_e          state_q,    state_d;
   logic [EP_CNT_W-1:0] pkt_len_q,  pkt_len_d;
   logic [EP_CNT_W-1:0] down_q,     down_d;
   logic                eop_pend_q, eop_pend_d;

   // Combinational steering and handshake terms.
   logic                dir_in;
   logic                clr;
   logic [EP_CNT_W-1:0] mps;
   logic                push_req;
   logic [7:0]          push_data;
   logic                pop_raw;
   logic                zlp_ack;
   logic                pop_req;
   logic                empty;
   logic                full;
   logic                do_push;
   logic                do_pop;
   logic [7:0]          head;
   logic                pkt_done;
   logic                commit_ok;
   logic [EP_CNT_W-1:0] commit_len;

   // Route strobes from whichever side is active for the current direction.
   // A core pop that acknowledges a zero-length packet moves no data.
   always_comb begin
      dir_in    = cfg_i[EP_CFG_DIR];
      clr       = flush | (cfg_i[EP_CFG_DIR] ^ cfg_q[EP_CFG_DIR]);
      mps       = cfg_i[EP_CFG_MPS_MSB:EP_CFG_MPS_LSB];
      push_req  = dir_in ? f_we    : ep_we;
      push_data = dir_in ? f_wdata : ep_dout;
      pop_raw   = dir_in ? ep_re   : f_re;
      zlp_ack   = dir_in & ep_re & (state_q == PKT_READY) & (pkt_len_q == '0);
      pop_req   = pop_raw & ~zlp_ack;
   end

   // FIFO datapath: accept/reject pushes and pops, advance pointers and count.
   // A pop on full always makes room for a same-cycle push; a push on empty
   // supplies nothing to a same-cycle pop, so only the push takes effect.
   // NOTE: every signal written here is assigned before any branch, so no
   // path leaves a value held and no latch is inferred.
   always_comb begin
      cfg_d     = cfg_i;
      empty     = (count_q == '0);
      full      = (count_q == DEPTH_CNT);
      do_pop    = pop_req & ~empty;
      do_push   = push_req & (~full | do_pop);
      err_ovf_d = push_req & full & ~pop_req;
      err_udf_d = pop_req & empty & ~push_req;
      wr_ptr_d  = wr_ptr_q + AW'(do_push);
      rd_ptr_d  = rd_ptr_q + AW'(do_pop);
      count_d   = count_q + EP_CNT_W'(do_push) - EP_CNT_W'(do_pop);
      if (clr) begin
         do_push   = 1'b0;
         do_pop    = 1'b0;
         err_ovf_d = 1'b0;
         err_udf_d = 1'b0;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
      end
   end

   // IN packet framing. Bytes not yet in a committed packet are "pending";
   // whenever no packet is outstanding (IDLE, or the cycle the last byte of
   // one leaves) pending equals next-cycle occupancy, so count_d decides the
   // commit. An f_eop seen while a packet is busy is remembered for later.
   always_comb begin
      state_d    = state_q;
      pkt_len_d  = pkt_len_q;
      down_d     = down_q;
      eop_pend_d = eop_pend_q;
      pkt_done   = 1'b0;
      commit_ok  = f_eop | eop_pend_q | (count_d >= mps);
      commit_len = (count_d < mps) ? count_d : mps;

      unique case (state_q)
         PKT_IDLE: begin
         end
         PKT_READY: begin
            if (ep_re) begin
               if (pkt_len_q <= EP_CNT_W'(1)) begin
                  pkt_done = 1'b1;
               end else begin
                  state_d = PKT_XFER;
                  down_d  = pkt_len_q - EP_CNT_W'(1);
               end
            end
         end
         PKT_XFER: begin
            if (ep_re) begin
               down_d = down_q - EP_CNT_W'(1);
               if (down_q == EP_CNT_W'(1)) begin
                  pkt_done = 1'b1;
               end
            end
         end
         default: begin
            state_d = PKT_IDLE;
         end
      endcase

      if ((state_q == PKT_IDLE) || pkt_done) begin
         if (commit_ok) begin
            state_d    = PKT_READY;
            pkt_len_d  = commit_len;
            down_d     = '0;
            eop_pend_d = 1'b0;
         end else begin
            state_d   = PKT_IDLE;
            pkt_len_d = '0;
            down_d    = '0;
         end
      end else if (f_eop) begin
         eop_pend_d = 1'b1;
      end

      if (!dir_in || clr) begin
         state_d    = PKT_IDLE;
         pkt_len_d  = '0;
         down_d     = '0;
         eop_pend_d = 1'b0;
      end
   end

   // State registers; everything except the byte array clears on reset.
   // NOTE: non-blocking assignments here so every flop samples the values
   // computed before the edge, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         err_ovf_q  <= 1'b0;
         err_udf_q  <= 1'b0;
         state_q    <= PKT_IDLE;
         pkt_len_q  <= '0;
         down_q     <= '0;
         eop_pend_q <= 1'b0;
      end else begin
         cfg_q      <= cfg_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         err_ovf_q  <= err_ovf_d;
         err_udf_q  <= err_udf_d;
         state_q    <= state_d;
         pkt_len_q  <= pkt_len_d;
         down_q     <= down_d;
         eop_pend_q <= eop_pend_d;
      end
   end

   usb_ep_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (do_push),
      .waddr (wr_ptr_q),
      .wdata (push_data),
      .raddr (rd_ptr_q),
      .rdata (head)
   );

   // Output mapping; packet size reads zero whenever no packet is offered.
   always_comb begin
      ep_cfg     = cfg_q;
      ep_din     = head;
      f_rdata    = head;
      ep_empty   = empty;
      ep_full    = full;
      f_count    = count_q;
      ep_bf_en   = (state_q == PKT_READY);
      ep_bf_size = (state_q == PKT_READY) ? pkt_len_q : '0;
      err_ovf    = err_ovf_q;
      err_udf    = err_udf_q;
   end

endmodule

// File: tb/tb_usb_ep_fifo.sv
// Scoreboard bench for usb_ep_fifo. The driver applies inputs on the falling
// edge, steps a queue-based reference model and pushes the expected
// post-edge outputs; the monitor pops one expectation after every rising
// edge and compares it with the DUT.
module tb_usb_ep_fifo;
   import usb_ep_pkg::*;

   localparam int unsigned DEPTH = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic [13:0] cfg_i;
   logic [13:0] ep_cfg;
   logic [7:0]  ep_din;
   logic        ep_re;
   logic [7:0]  ep_dout;
   logic        ep_we;
   logic        ep_empty, ep_full, ep_bf_en;
   logic [6:0]  ep_bf_size;
   logic [7:0]  f_wdata;
   logic        f_we, f_eop;
   logic [7:0]  f_rdata;
   logic        f_re;
   logic [6:0]  f_count;
   logic        flush;
   logic        err_ovf, err_udf;

   usb_ep_fifo #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .cfg_i      (cfg_i),
      .ep_cfg     (ep_cfg),
      .ep_din     (ep_din),
      .ep_re      (ep_re),
      .ep_dout    (ep_dout),
      .ep_we      (ep_we),
      .ep_empty   (ep_empty),
      .ep_full    (ep_full),
      .ep_bf_en   (ep_bf_en),
      .ep_bf_size (ep_bf_size),
      .f_wdata    (f_wdata),
      .f_we       (f_we),
      .f_eop      (f_eop),
      .f_rdata    (f_rdata),
      .f_re       (f_re),
      .f_count    (f_count),
      .flush      (flush),
      .err_ovf    (err_ovf),
      .err_udf    (err_udf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] cfg;
      logic        empty;
      logic        full;
      logic [6:0]  count;
      logic        bf_en;
      logic [6:0]  bf_size;
      logic        has_head;
      logic [7:0]  head;
      logic        ovf;
      logic        udf;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // Reference model: byte queue plus a description of the offered packet.
   logic [7:0]  m_q[$];
   logic [13:0] m_cfg;
   bit          m_act;       // a packet is committed
   bit          m_started;   // the core has begun popping it
   bit          m_eop_pend;  // end-of-packet seen while a packet was busy
   int          m_size;      // committed packet length
   int          m_rem;       // bytes of it still in the FIFO
   bit          m_ovf, m_udf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, req, $time);
      end
   endtask

   task automatic model_step();
      bit         dir, push, pop, zlp, popped, pushed, done;
      int         pre_n, mps;
      logic [7:0] wdata;
      if (rst) begin
         m_q.delete();
         m_cfg = '0; m_act = 0; m_started = 0; m_eop_pend = 0;
         m_size = 0; m_rem = 0; m_ovf = 0; m_udf = 0;
         return;
      end
      dir   = cfg_i[13];
      m_ovf = 0;
      m_udf = 0;
      if (flush || (dir != m_cfg[13])) begin
         m_cfg = cfg_i;
         m_q.delete();
         m_act = 0; m_started = 0; m_eop_pend = 0;
         return;
      end
      m_cfg  = cfg_i;
      mps    = int'(cfg_i[6:0]);
      push   = dir ? f_we : ep_we;
      wdata  = dir ? f_wdata : ep_dout;
      zlp    = dir && ep_re && m_act && !m_started && (m_size == 0);
      pop    = (dir ? ep_re : f_re) && !zlp;
      pre_n  = m_q.size();
      popped = pop && (pre_n > 0);
      pushed = push && ((pre_n < int'(DEPTH)) || popped);
      m_ovf  = push && (pre_n == int'(DEPTH)) && !pop;
      m_udf  = pop && (pre_n == 0) && !push;
      if (popped) void'(m_q.pop_front());
      if (pushed) m_q.push_back(wdata);
      if (!dir) return;
      done = 0;
      if (m_act && ep_re) begin
         if (zlp) done = 1;
         else begin
            m_started = 1;
            m_rem--;
            if (m_rem == 0) done = 1;
         end
      end
      if (!m_act || done) begin
         if (f_eop || m_eop_pend || (m_q.size() >= mps)) begin
            m_act      = 1;
            m_started  = 0;
            m_size     = (m_q.size() < mps) ? m_q.size() : mps;
            m_rem      = m_size;
            m_eop_pend = 0;
         end else begin
            m_act = 0;
         end
      end else if (f_eop) begin
         m_eop_pend = 1;
      end
   endtask

   // Step the model for the inputs now applied, queue the expectation and
   // hold the inputs across the next rising edge.
   task automatic tick();
      exp_t e;
      model_step();
      e.cfg      = m_cfg;
      e.count    = 7'(m_q.size());
      e.empty    = (m_q.size() == 0);
      e.full     = (m_q.size() == int'(DEPTH));
      e.bf_en    = m_act && !m_started;
      e.bf_size  = e.bf_en ? 7'(m_size) : 7'd0;
      e.has_head = (m_q.size() > 0);
      e.head     = e.has_head ? m_q[0] : 8'h00;
      e.ovf      = m_ovf;
      e.udf      = m_udf;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle();
      ep_re = 0; ep_we = 0; f_we = 0; f_re = 0; f_eop = 0; flush = 0;
   endtask

   task automatic set_cfg(input bit dir, input int mps);
      idle();
      cfg_i = {dir, 6'($urandom), 7'(mps)};
      tick();
   endtask

   // Monitor: compare the DUT with the oldest expectation after each edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ep_cfg",     32'(ep_cfg),     32'(e.cfg));
            check("ep_empty",   32'(ep_empty),   32'(e.empty));
            check("ep_full",    32'(ep_full),    32'(e.full));
            check("f_count",    32'(f_count),    32'(e.count));
            check("ep_bf_en",   32'(ep_bf_en),   32'(e.bf_en));
            check("ep_bf_size", 32'(ep_bf_size), 32'(e.bf_size));
            check("err_ovf",    32'(err_ovf),    32'(e.ovf));
            check("err_udf",    32'(err_udf),    32'(e.udf));
            if (e.has_head) begin
               check("ep_din",  32'(ep_din),  32'(e.head));
               check("f_rdata", 32'(f_rdata), 32'(e.head));
            end
         end
      end
   end

   // Driver: directed scenarios followed by randomized traffic.
   initial begin
      idle();
      cfg_i = '0; ep_dout = '0; f_wdata = '0;
      rst = 1;
      repeat (3) tick();
      rst = 0;
      tick();

      // IN, max packet 8: eight bytes form a packet, then drain it.
      set_cfg(1, 8);
      for (int i = 1; i <= 8; i++) begin
         f_we = 1; f_wdata = 8'(i); tick();
      end
      idle(); tick();
      for (int i = 0; i < 8; i++) begin
         ep_re = 1; tick();
      end
      idle(); tick();

      // IN: short packet closed by f_eop, then drained.
      for (int i = 0; i < 3; i++) begin
         f_we = 1; f_wdata = 8'(8'h11 + i); tick();
      end
      idle(); f_eop = 1; tick();
      idle(); tick();
      for (int i = 0; i < 3; i++) begin
         ep_re = 1; tick();
      end
      idle(); tick();

      // IN: zero-length packet acknowledged by one core pop.
      f_eop = 1; tick();
      idle(); tick();
      ep_re = 1; tick();
      idle(); tick();

      // OUT: fill to full, then one rejected push.
      set_cfg(0, 8);
      for (int i = 0; i < 65; i++) begin
         ep_we = 1; ep_dout = 8'(8'h40 + i); tick();
      end
      idle(); tick();

      // OUT: push and pop together at full (pointers wrap), drain past empty,
      // then push and pop together at empty.
      for (int i = 0; i < 5; i++) begin
         ep_we = 1; f_re = 1; ep_dout = 8'(8'hA0 + i); tick();
      end
      idle();
      for (int i = 0; i < 65; i++) begin
         f_re = 1; tick();
      end
      idle();
      ep_we = 1; f_re = 1; ep_dout = 8'h5A; tick();
      idle(); tick();

      // OUT: strobes of the inactive side move nothing and flag nothing.
      ep_re = 1; f_we = 1; f_wdata = 8'hEE; f_eop = 1; tick();
      idle(); tick();
      f_re = 1; tick();
      idle(); tick();

      // IN: flush mid-transfer, then reset mid-transfer.
      set_cfg(1, 16);
      for (int i = 0; i < 16; i++) begin
         f_we = 1; f_wdata = 8'($urandom); tick();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         ep_re = 1; tick();
      end
      idle(); flush = 1; f_we = 1; ep_re = 1; tick();
      idle(); tick();
      for (int i = 0; i < 16; i++) begin
         f_we = 1; f_wdata = 8'($urandom); tick();
      end
      idle();
      for (int i = 0; i < 3; i++) begin
         ep_re = 1; tick();
      end
      idle(); rst = 1; tick();
      rst = 0; tick();
      tick();

      // Randomized traffic in both directions with varying fill bias.
      for (int ph = 0; ph < 10; ph++) begin
         int push_pct;
         int pop_pct;
         push_pct = (ph % 3 == 0) ? 80 : ((ph % 3 == 1) ? 25 : 50);
         pop_pct  = 100 - push_pct;
         set_cfg(1'($urandom_range(0, 1)), $urandom_range(1, 70));
         for (int c = 0; c < 400; c++) begin
            f_we    = ($urandom_range(0, 99) < push_pct);
            ep_we   = ($urandom_range(0, 99) < push_pct);
            ep_re   = ($urandom_range(0, 99) < pop_pct);
            f_re    = ($urandom_range(0, 99) < pop_pct);
            f_eop   = ($urandom_range(0, 99) < 5);
            flush   = ($urandom_range(0, 199) == 0);
            f_wdata = 8'($urandom);
            ep_dout = 8'($urandom);
            tick();
         end
      end

      idle();
      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
